pipeline_sink: RTL and testbench
================================

Name: pipeline_sink

Overview:
- Receive-side end of a fixed-latency, enable-driven data pipeline. It captures words arriving from the pipeline output into a small FIFO and presents them downstream with a valid/ready handshake.
- Upstream may only launch a word into the pipeline when it holds a credit. This block owns the credit count, so no in-flight word is ever dropped when the downstream consumer stalls.
- Placed directly after a delay-line pipeline whose stages cannot be stalled once a word is issued.

Parameters:
DWIDTH, 1, width of data words
DEPTH, 4, FIFO entries and total credits; power of two, >= 2; must be >= upstream pipeline latency for full throughput

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
i_issue  input  1  upstream launched one word into the pipeline this cycle (consumes one credit)
o_can_issue  output  1  at least one credit available
i_valid  input  1  word arriving from the pipeline output this cycle
i_data  input  DWIDTH  arriving word
o_valid  output  1  FIFO head (or bypass word) valid downstream
o_data  output  DWIDTH  head word
i_ready  input  1  downstream accepts o_data when o_valid && i_ready
o_count  output  $clog2(DEPTH)+1  current FIFO occupancy
o_error  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, asynchronous): clear rd/wr pointers and occupancy; set credits=DEPTH, o_error=0. Outputs during reset: o_valid=0, o_can_issue=1, o_count=0, o_data=0. Storage contents are not reset.
- Credits (0..DEPTH):
  - Decrement on i_issue; increment on pop (o_valid && i_ready). Both in the same cycle: unchanged.
  - o_can_issue = (credits != 0), a pure function of the registered count.
- i_issue with credits==0: count stays 0; o_error set.
- Write: when i_valid=1 (and not bypassed), store i_data at wr_ptr, advance wr_ptr modulo DEPTH, occupancy+1.
- Read (first-word-fall-through):
  - o_valid = (occupancy != 0); o_data = mem[rd_ptr].
  - On pop, advance rd_ptr modulo DEPTH, occupancy-1.
- Write latency: a word written on edge N shows o_valid=1 after edge N when the FIFO was empty. That is a minimum 1-cycle i_valid-to-o_valid latency (non-bypass build).
- Full and i_valid=1:
  - With a pop in the same cycle: the write is accepted (read-before-write); occupancy stays DEPTH.
  - Without a pop: the word is dropped, state is unchanged, o_error is set.
- Simultaneous write and pop on a non-full FIFO: occupancy unchanged; both pointers advance.
- Pop while empty cannot occur, because o_valid=0.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0; occupancy disambiguates full from empty.
- Invariant when upstream obeys credits: credits + occupancy + in-flight = DEPTH. Overflow is then impossible.
- o_error clears only on reset.
- Reset asserted mid-operation: FIFO contents are discarded and credits restored to DEPTH immediately. Upstream must flush its pipeline under the same reset.

Optional Feature:
- Macro: PIPELINE_SINK_BYPASS_EN.
- Defined:
  - When occupancy==0 and i_valid=1: o_valid=1 and o_data=i_data combinationally in the same cycle.
  - If i_ready=1 that cycle, the word is popped (credit returned) and not written to the FIFO.
  - If i_ready=0, the word is written normally.
  - Zero-cycle latency when empty.
- Undefined: no combinational path from i_valid/i_data to o_valid/o_data; all outputs except the FWFT o_data mux are register-driven.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, release -> o_valid=0, o_can_issue=1, o_count=0, o_error=0. Assert rst=0 mid-stream with o_count=3 -> o_count=0, o_can_issue=1 immediately.
2. Credit exhaustion (DEPTH=4): i_issue=1 for 4 cycles with i_ready=0 -> o_can_issue=0 after the 4th edge. A 5th i_issue -> o_error=1 and credits stay 0.
3. Backpressure fill: i_ready=0, push 0x1,0x2,0x3,0x4 -> o_count=4. Set i_ready=1 -> outputs 0x1..0x4 in order on consecutive cycles, credits back to 4.
4. Full plus simultaneous push/pop: o_count=4, i_valid=1 with 0x5, i_ready=1 -> pops 0x1, accepts 0x5, o_count stays 4, o_error stays 0.
5. Overflow: o_count=4, i_ready=0, i_valid=1 -> o_count=4, the word is dropped, o_error=1 and stays 1 until reset.
6. Wrap and latency: stream 10 words at 1 word/cycle with i_ready=1 -> all 10 delivered in order (pointers wrap twice). First o_valid is 1 cycle after the first i_valid, or 0 cycles with PIPELINE_SINK_BYPASS_EN defined, in which case o_count stays 0 throughout.

Source files
------------

// File: rtl/pipeline_sink.sv
// Receive-side end of a fixed-latency pipeline: credit-managed FWFT FIFO with valid/ready output.
// Build option: define PIPELINE_SINK_BYPASS_EN for a zero-latency empty-FIFO bypass.
module pipeline_sink #(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_issue,
    output logic                     o_can_issue,
    input  logic                     i_valid,
    input  logic [DWIDTH-1:0]        i_data,
    output logic                     o_valid,
    output logic [DWIDTH-1:0]        o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     occ, credits;
    logic              empty, full, bypass, pop, rd_adv, wr_en;
    logic              ovf_err, issue_err;

    assign empty = (occ == '0);
    assign full  = (occ == CW'(DEPTH));

`ifdef PIPELINE_SINK_BYPASS_EN
    assign bypass  = empty && i_valid;
    assign o_valid = !empty || i_valid;
    assign o_data  = !empty ? mem[rd_ptr] : (i_valid ? i_data : '0);
`else
    assign bypass  = 1'b0;
    assign o_valid = !empty;
    assign o_data  = empty ? '0 : mem[rd_ptr];
`endif

    assign pop    = o_valid && i_ready;
    // A bypassed word is consumed directly and never touches the FIFO pointers.
    assign rd_adv = pop && !empty;
    assign wr_en  = i_valid && !(bypass && i_ready) && (!full || pop);

    assign ovf_err   = i_valid && full && !pop;
    assign issue_err = i_issue && (credits == '0);

    assign o_count     = occ;
    assign o_can_issue = (credits != '0);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
            credits <= CW'(DEPTH);
            o_error <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;

            case ({wr_en, rd_adv})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            // Saturate at DEPTH so a misbehaving upstream cannot inflate the credit pool.
            if (pop && !i_issue && credits != CW'(DEPTH))
                credits <= credits + 1'b1;
            else if (i_issue && !pop && credits != '0)
                credits <= credits - 1'b1;

            if (ovf_err || issue_err) o_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed self-checking bench for pipeline_sink (DWIDTH=8, DEPTH=4).
module tb_pipeline_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_issue, i_valid, i_ready;
    logic [7:0] i_data;
    logic       o_can_issue, o_valid, o_error;
    logic [7:0] o_data;
    logic [2:0] o_count;

    int n_tests = 0;
    int n_fail  = 0;
    int first_valid;
    int got;

    pipeline_sink #(.DWIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_issue(i_issue), .o_can_issue(o_can_issue),
        .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready),
        .o_count(o_count), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_issue = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            i_issue = 1'b1;
            i_valid = 1'b1;
            i_ready = 1'b0;
            i_data  = base + 8'(k);
            tick();
        end
        idle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_can_issue", o_can_issue, 1);
        chk("rst_count", o_count, 0);
        chk("rst_data", o_data, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_error", o_error, 0);
        chk("post_rst_valid", o_valid, 0);

        // credit exhaustion
        for (int k = 0; k < 4; k++) begin
            i_issue = 1'b1;
            tick();
            if (k == 2) chk("credit_3rd", o_can_issue, 1);
        end
        chk("credit_4th", o_can_issue, 0);
        chk("credit_no_err", o_error, 0);
        tick();
        chk("credit_5th_err", o_error, 1);
        chk("credit_5th_can", o_can_issue, 0);
        idle();
        do_reset();
        chk("reset_clears_err", o_error, 0);

        // backpressure fill, then full with simultaneous push/pop
        fill(4, 8'h01);
        chk("fill_count", o_count, 4);
        chk("fill_can_issue", o_can_issue, 0);
        chk("fill_head", o_data, 8'h01);
        i_valid = 1'b1;
        i_data  = 8'h05;
        i_ready = 1'b1;
        #1;
        chk("swap_pop_data", o_data, 8'h01);
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        chk("swap_count", o_count, 4);
        chk("swap_error", o_error, 0);
        for (int k = 2; k <= 5; k++) begin
            i_ready = 1'b1;
            #1;
            chk("drain_valid", o_valid, 1);
            chk("drain_data", o_data, 32'(k));
            tick();
        end
        idle();
        #1;
        chk("drain_empty", o_valid, 0);
        chk("drain_count", o_count, 0);
        for (int k = 0; k < 4; k++) begin
            chk("credits_back", o_can_issue, 1);
            i_issue = 1'b1;
            tick();
        end
        chk("credits_exact4", o_can_issue, 0);
        idle();
        do_reset();

        // overflow drops the word and sets the sticky error
        fill(4, 8'h01);
        i_valid = 1'b1;
        i_data  = 8'hAA;
        tick();
        idle();
        #1;
        chk("ovf_count", o_count, 4);
        chk("ovf_error", o_error, 1);
        for (int k = 1; k <= 4; k++) begin
            i_ready = 1'b1;
            #1;
            chk("ovf_drain_data", o_data, 32'(k));
            tick();
        end
        idle();
        #1;
        chk("ovf_dropped", o_valid, 0);
        chk("ovf_error_sticky", o_error, 1);
        do_reset();

        // asynchronous reset mid-stream
        fill(3, 8'h40);
        chk("mid_count", o_count, 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_can", o_can_issue, 1);
        chk("mid_rst_valid", o_valid, 0);
        tick();
        rst = 1'b1;
        #1;

        // streaming with pointer wrap
        first_valid = -1;
        got = 0;
        for (int c = 0; c < 14; c++) begin
            i_ready = 1'b1;
            i_valid = (c < 10);
            i_issue = (c < 10);
            i_data  = 8'h10 + 8'(c);
            #1;
            if (o_valid) begin
                if (first_valid < 0) first_valid = c;
                chk("stream_data", o_data, 32'h10 + 32'(got));
                got++;
            end
`ifdef PIPELINE_SINK_BYPASS_EN
            chk("bypass_count", o_count, 0);
`endif
            tick();
        end
        idle();
        #1;
        chk("stream_words", got, 10);
`ifdef PIPELINE_SINK_BYPASS_EN
        chk("stream_latency", first_valid, 0);
`else
        chk("stream_latency", first_valid, 1);
`endif
        chk("stream_count", o_count, 0);
        chk("stream_error", o_error, 0);
        chk("stream_can", o_can_issue, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
